mac_sa_acc: RTL and testbench

Parametrised shift-add multiply-accumulate unit, the successor to the fixed 256-bit shift-add MAC. It computes an unsigned W×W product, one multiplier bit per cycle, over a ripple-carry adder. It adds a start/busy/done handshake, an optional accumulate mode with guard bits and a sticky overflow flag, and per-cycle stall via `en`. It sits behind a host or sequencer that issues one operation at a time and reads `out` on `done`.

---
 rtl/mac_sa_acc.sv | 135 +++++++++++++
 tb/tb_mac_sa_acc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_sa_acc.sv
// rtl/mac_sa_acc.sv - shift-add unsigned multiply-accumulate unit
//
// Computes A*B one multiplier bit per cycle and either writes or accumulates
// the 2W-bit product into a (2W+G)-bit result register with a sticky carry-out
// flag.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        clock enable; all state holds when low, except for clr_acc
//   start     request a new operation (accepted only in IDLE with en=1)
//   A, B      multiplicand / multiplier, captured on the accepted start
//   acc_mode  captured on start: 1 = out += A*B, 0 = out = A*B
//   clr_acc   synchronous clear of out and ovf
//   busy      high from the start-accept edge until the result-write edge
//   done      one-cycle pulse after out is written
//   out       result / accumulator register, 2W+G bits
//   ovf       sticky flag, set when an accumulation carries out of out
//
// Optional feature: define MAC_SA_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits are all zero (at least one iteration is done).

module mac_sa_acc #(
    parameter int W = 256,
    parameter int G = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             acc_mode,
    input  logic             clr_acc,
    output logic             busy,
    output logic             done,
    output logic [2*W+G-1:0] out,
    output logic             ovf
);

    localparam int ACC_W = 2 * W + G;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [2*W-1:0]     mc;
    logic [W-1:0]       mr;
    logic [2*W-1:0]     p;
    logic [CNT_W-1:0]   cnt;
    logic               acc_q;
    logic               last_iter;
    logic [ACC_W-1:0]   old_val;
    logic [ACC_W:0]     sum;

`ifdef MAC_SA_EARLY_TERM_EN
    // The iteration in progress is the last useful one when the multiplier
    // bits that remain after this shift are all zero.
    assign last_iter = ((mr >> 1) == '0) || (cnt == CNT_W'(W - 1));
`else
    assign last_iter = (cnt == CNT_W'(W - 1));
`endif

    // A clear coinciding with the write makes the old value 0, so the
    // carry-out of this sum is the only thing that can set ovf afterwards.
    assign old_val = (clr_acc || !acc_q) ? '0 : out;
    assign sum     = {1'b0, old_val} + {{(G + 1){1'b0}}, p};
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && en) state_n = RUN;
            RUN:     if (en && last_iter) state_n = FIN;
            FIN:     if (en) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc    <= '0;
            mr    <= '0;
            p     <= '0;
            cnt   <= '0;
            acc_q <= 1'b0;
            out   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            // done is a single-cycle pulse independent of en.
            done <= 1'b0;

            if (state == IDLE && start && en) begin
                mc    <= {{W{1'b0}}, A};
                mr    <= B;
                p     <= '0;
                cnt   <= '0;
                acc_q <= acc_mode;
            end

            if (state == RUN && en) begin
                if (mr[0]) begin
                    p <= p + mc;
                end
                mc  <= mc << 1;
                mr  <= mr >> 1;
                cnt <= cnt + CNT_W'(1);
            end

            if (state == FIN && en) begin
                out  <= sum[ACC_W-1:0];
                ovf  <= clr_acc ? sum[ACC_W] : (ovf | sum[ACC_W]);
                done <= 1'b1;
            end else if (clr_acc) begin
                out <= '0;
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_sa_acc.sv
// tb/tb_mac_sa_acc.sv - self-checking bench for mac_sa_acc (W=8, G=4)

module tb_mac_sa_acc;

    localparam int W     = 8;
    localparam int G     = 4;
    localparam int ACC_W = 2 * W + G;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             start;
    logic [W-1:0]     A;
    logic [W-1:0]     B;
    logic             acc_mode;
    logic             clr_acc;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] out;
    logic             ovf;

    int checks;
    int errors;

    // Reference state: the value out and ovf should hold.
    logic [ACC_W-1:0] m_out;
    logic             m_ovf;

    mac_sa_acc #(.W(W), .G(G)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .start    (start),
        .A        (A),
        .B        (B),
        .acc_mode (acc_mode),
        .clr_acc  (clr_acc),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from accept edge to the edge that writes out, with en held high.
    function automatic int exp_lat(input logic [W-1:0] b);
        int k;
`ifdef MAC_SA_EARLY_TERM_EN
        k = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) k = i + 1;
        end
`else
        k = W;
`endif
        return k + 1;
    endfunction

    // One full operation. Called just after a rising edge with the DUT idle.
    // Stall window is [stall_at, stall_at+stall_len) in edges after accept;
    // clr_at (0 = none) pulses clr_acc before that edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic acc, input int stall_at,
                          input int stall_len, input int clr_at,
                          input string name);
        logic [ACC_W:0]   s;
        logic [2*W-1:0]   prod;
        int               lat;
        int               got;
        bit               busy_bad;

        prod = 2 * W'(0) + a * b;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        lat  = exp_lat(b) + stall_len;

        A = a; B = b; acc_mode = acc; start = 1'b1; en = 1'b1; clr_acc = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; A = W'($urandom); B = W'($urandom); acc_mode = ~acc;

        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
        end

        got = -1;
        busy_bad = 0;
        for (int i = 1; i <= 300; i++) begin
            en      = !(i >= stall_at && i < stall_at + stall_len);
            start   = (i == 2);
            A       = W'($urandom);
            B       = W'($urandom);
            clr_acc = (i == clr_at);
            @(posedge clk); #1;
            if (done === 1'b1) begin
                got = i;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1;
        end
        en = 1'b1; start = 1'b0; clr_acc = 1'b0;

        if (clr_at > 0) begin
            m_out = '0;
            m_ovf = 1'b0;
        end
        s = {1'b0, (acc ? m_out : {ACC_W{1'b0}})} + {{(G + 1){1'b0}}, prod};
        if (acc && s[ACC_W]) m_ovf = 1'b1;
        m_out = s[ACC_W-1:0];

        checks++;
        if (got != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, got, lat);
        end
        checks++;
        if (out !== m_out || ovf !== m_ovf) begin
            errors++;
            $display("FAIL %s result: out=%0d ovf=%b, required out=%0d ovf=%b",
                     name, out, ovf, m_out, m_ovf);
        end
        checks++;
        if (busy !== 1'b0 || busy_bad) begin
            errors++;
            $display("FAIL %s busy: busy_at_done=%b dropped_early=%0d, required 0/0",
                     name, busy, busy_bad);
        end
    endtask

    task automatic apply_clr(input logic en_val, input string name);
        clr_acc = 1'b1; en = en_val;
        @(posedge clk); #1;
        clr_acc = 1'b0; en = 1'b1;
        m_out = '0; m_ovf = 1'b0;
        checks++;
        if (out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s: out=%0d ovf=%b, required out=0 ovf=0", name, out, ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; start = 1'b0; A = '0; B = '0;
        acc_mode = 1'b0; clr_acc = 1'b0;
        m_out = '0; m_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b out=%0d ovf=%b, required all 0",
                     busy, done, out, ovf);
        end
        rst_n = 1'b1; en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fixed();
        run_op(8'd255, 8'd255, 1'b0, 0, 0, 0, "mul_255x255");
        checks++;
        if (out !== ACC_W'(65025)) begin
            errors++;
            $display("FAIL mul_255x255 const: out=%0d, required 65025", out);
        end
    endtask

    task automatic test_accumulate();
        apply_clr(1'b1, "clr_idle");
        run_op(8'd3, 8'd4, 1'b1, 0, 0, 0, "acc_3x4");
        checks++;
        if (out !== ACC_W'(12)) begin
            errors++;
            $display("FAIL acc_3x4 const: out=%0d, required 12", out);
        end
        run_op(8'd5, 8'd6, 1'b1, 0, 0, 0, "acc_5x6");
        checks++;
        if (out !== ACC_W'(42) || ovf !== 1'b0) begin
            errors++;
            $display("FAIL acc_5x6 const: out=%0d ovf=%b, required 42/0", out, ovf);
        end
    endtask

    task automatic test_overflow();
        apply_clr(1'b0, "clr_idle_en0");
        for (int i = 0; i < 17; i++) begin
            run_op(8'd255, 8'd255, 1'b1, 0, 0, 0, "ovf_acc");
        end
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b, required 1", ovf);
        end
        run_op(8'd7, 8'd9, 1'b0, 0, 0, 0, "ovf_sticky");
        apply_clr(1'b1, "clr_after_ovf");
    endtask

    task automatic test_stall();
        run_op(8'd200, 8'd150, 1'b0, 3, 3, 0, "stall_3");
        run_op(8'd17, 8'd33, 1'b1, 2, 2, 4, "clr_in_run");
    endtask

    task automatic test_early_cases();
        run_op(8'd77, 8'd1, 1'b0, 0, 0, 0, "b_one");
        run_op(8'd99, 8'd0, 1'b0, 0, 0, 0, "b_zero");
        run_op(8'd3, 8'h80, 1'b0, 0, 0, 0, "b_msb");
        checks++;
        if (out !== ACC_W'(384)) begin
            errors++;
            $display("FAIL b_msb const: out=%0d, required 384", out);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int sa, sl, ca;
            a  = W'($urandom);
            b  = (n % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            sa = $urandom_range(1, 6);
            sl = $urandom_range(0, 3);
            ca = ($urandom_range(0, 3) == 0) ? $urandom_range(1, exp_lat(b)) : 0;
            run_op(a, b, 1'($urandom), sa, sl, ca, "random");
        end
    endtask

    task automatic test_reset_mid();
        A = 8'd123; B = 8'd211; acc_mode = 1'b1; start = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b out=%0d ovf=%b, required all 0",
                     busy, done, out, ovf);
        end
        m_out = '0; m_ovf = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd45, 8'd67, 1'b1, 0, 0, 0, "after_reset_mid");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fixed();
        test_accumulate();
        test_overflow();
        test_stall();
        test_early_cases();
        test_back_to_back_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
